imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe.sv | 189 ++++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
//   Decodes the immediate field of a RISC-V style instruction word and
//   buffers the result in a small valid/ready FIFO so that upstream and
//   downstream can stall independently.
//
// Parameters
//   XLEN        datapath width of out_imm (32 or 64)
//   DEPTH       number of buffer entries (power of two, >= 2)
//   TAG_W       width of the opaque sideband tag
//   AUTO_DECODE 1: format derived from the opcode, 0: format from in_imm_sel
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   flush              synchronous discard of all buffered beats
//   in_valid/in_ready  input handshake
//   in_instr           32-bit instruction word
//   in_imm_sel         format select (only used when AUTO_DECODE = 0)
//   in_tag             sideband data carried alongside the beat
//   out_valid/out_ready output handshake
//   out_imm            extended immediate of the head beat
//   out_fmt            format code applied to the head beat
//   out_illegal        head beat had an unknown opcode or reserved format
//   out_tag            in_tag of the head beat
//   illegal_cnt        saturating count of illegal beats accepted
module imm_gen_pipe #(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 2,
  parameter int TAG_W       = 5,
  parameter int AUTO_DECODE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [15:0]      illegal_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [2:0] FMT_R     = 3'b000;
  localparam logic [2:0] FMT_I     = 3'b001;
  localparam logic [2:0] FMT_S     = 3'b010;
  localparam logic [2:0] FMT_B     = 3'b011;
  localparam logic [2:0] FMT_U     = 3'b100;
  localparam logic [2:0] FMT_J     = 3'b101;
  localparam logic [2:0] FMT_SHAMT = 3'b110;
  localparam logic [2:0] FMT_RSVD  = 3'b111;

  logic [2:0]         dec_fmt;
  logic               dec_illegal;
  logic signed [31:0] imm32;
  logic [XLEN-1:0]    dec_imm;

  logic [XLEN-1:0]  imm_mem [DEPTH];
  logic [2:0]       fmt_mem [DEPTH];
  logic             ill_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  // Format selection: either the opcode map or the externally supplied
  // select. Unknown opcodes fall back to R (immediate 0) and are flagged.
  always_comb begin
    dec_fmt     = FMT_R;
    dec_illegal = 1'b0;
    if (AUTO_DECODE != 0) begin
      case (in_instr[6:0])
        7'b0110011: dec_fmt = FMT_R;
        7'b0000011,
        7'b1100111,
        7'b1110011: dec_fmt = FMT_I;
        7'b0010011: begin
          // slli/srli/srai carry a shift amount instead of an I immediate
          if (in_instr[14:12] == 3'b001 || in_instr[14:12] == 3'b101)
            dec_fmt = FMT_SHAMT;
          else
            dec_fmt = FMT_I;
        end
        7'b0100011: dec_fmt = FMT_S;
        7'b1100011: dec_fmt = FMT_B;
        7'b0110111,
        7'b0010111: dec_fmt = FMT_U;
        7'b1101111: dec_fmt = FMT_J;
        default: begin
          dec_fmt     = FMT_R;
          dec_illegal = 1'b1;
        end
      endcase
    end else begin
      dec_fmt     = in_imm_sel;
      dec_illegal = (in_imm_sel == FMT_RSVD);
    end
  end

  // Immediates are first assembled as signed 32-bit values; widening to
  // XLEN then sign-extends them. SHAMT is built with a zero top bit so the
  // same widening zero-extends it.
  always_comb begin
    imm32 = '0;
    case (dec_fmt)
      FMT_I: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S: imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B: imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};
      FMT_U: imm32 = {in_instr[31:12], 12'b0};
      FMT_J: imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                      in_instr[20], in_instr[30:21], 1'b0};
      FMT_SHAMT: begin
        if (XLEN == 64)
          imm32 = {26'b0, in_instr[25:20]};
        else
          imm32 = {27'b0, in_instr[24:20]};
      end
      default: imm32 = '0;
    endcase
  end

  assign dec_imm = XLEN'(imm32);

  // Handshakes; flush wins over both so nothing moves in a flush cycle.
  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // Buffer storage needs no reset: entries are only visible through
  // out_valid, which is derived from the reset count.
  always_ff @(posedge clk) begin
    if (push) begin
      imm_mem[wr_ptr] <= dec_imm;
      fmt_mem[wr_ptr] <= dec_fmt;
      ill_mem[wr_ptr] <= dec_illegal;
      tag_mem[wr_ptr] <= in_tag;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)
        count <= count + CNT_W'(1);
      else if (pop && !push)
        count <= count - CNT_W'(1);
    end
  end

  // Illegal beats are counted when they enter the buffer; the count
  // survives flush and only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      illegal_cnt <= '0;
    else if (push && dec_illegal && illegal_cnt != 16'hFFFF)
      illegal_cnt <= illegal_cnt + 16'd1;
  end

  // Outputs are forced to zero whenever no beat is presented.
  assign out_imm     = out_valid ? imm_mem[rd_ptr] : '0;
  assign out_fmt     = out_valid ? fmt_mem[rd_ptr] : '0;
  assign out_illegal = out_valid ? ill_mem[rd_ptr] : 1'b0;
  assign out_tag     = out_valid ? tag_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe
//   Self-checking bench for imm_gen_pipe. Two instances (XLEN 32 and 64)
//   share one input stream; a queue-based reference model predicts the
//   buffer contents and the illegal counter from the decoding rules.
module tb_imm_gen_pipe;

  localparam int DEPTH = 2;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic [31:0]      in_instr = '0;
  logic [2:0]       in_imm_sel = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_ready = 1'b0;

  logic             in_ready, out_valid, out_illegal;
  logic [31:0]      out_imm;
  logic [2:0]       out_fmt;
  logic [TAG_W-1:0] out_tag;
  logic [15:0]      illegal_cnt;

  logic             w_in_ready, w_out_valid, w_out_illegal;
  logic [63:0]      w_out_imm;
  logic [2:0]       w_out_fmt;
  logic [TAG_W-1:0] w_out_tag;
  logic [15:0]      w_illegal_cnt;

  imm_gen_pipe #(.XLEN(32), .DEPTH(DEPTH), .TAG_W(TAG_W), .AUTO_DECODE(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_imm_sel(in_imm_sel), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_fmt(out_fmt), .out_illegal(out_illegal), .out_tag(out_tag),
    .illegal_cnt(illegal_cnt)
  );

  imm_gen_pipe #(.XLEN(64), .DEPTH(DEPTH), .TAG_W(TAG_W), .AUTO_DECODE(1)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(w_in_ready), .in_instr(in_instr),
    .in_imm_sel(in_imm_sel), .in_tag(in_tag),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_imm(w_out_imm),
    .out_fmt(w_out_fmt), .out_illegal(w_out_illegal), .out_tag(w_out_tag),
    .illegal_cnt(w_illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0]      imm32;
    logic [63:0]      imm64;
    logic [2:0]       fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } beat_t;

  beat_t model_q[$];
  int    ill_model = 0;
  int    total = 0;
  int    bad = 0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [63:0] got,
                             input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference decode written from the format rules using plain arithmetic.
  function automatic beat_t refDecode(input logic [31:0] ins,
                                      input logic [TAG_W-1:0] tg);
    beat_t  b;
    longint v;
    logic [2:0] f;
    logic il;
    f  = 3'd0;
    il = 1'b0;
    case (ins[6:0])
      7'h33: f = 3'd0;
      7'h03, 7'h67, 7'h73: f = 3'd1;
      7'h13: f = (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) ? 3'd6 : 3'd1;
      7'h23: f = 3'd2;
      7'h63: f = 3'd3;
      7'h37, 7'h17: f = 3'd4;
      7'h6F: f = 3'd5;
      default: il = 1'b1;
    endcase
    v = 0;
    b.imm32 = '0;
    b.imm64 = '0;
    case (f)
      3'd1: begin
        v = ins[31:20];
        if (ins[31]) v = v - 4096;
      end
      3'd2: begin
        v = {ins[31:25], ins[11:7]};
        if (ins[31]) v = v - 4096;
      end
      3'd3: begin
        v = {ins[31], ins[7], ins[30:25], ins[11:8]};
        v = v * 2;
        if (ins[31]) v = v - 8192;
      end
      3'd4: begin
        v = ins[31:12];
        v = v * 4096;
        if (ins[31]) v = v - 64'sh1_0000_0000;
      end
      3'd5: begin
        v = {ins[31], ins[19:12], ins[20], ins[30:21]};
        v = v * 2;
        if (ins[31]) v = v - 2097152;
      end
      default: v = 0;
    endcase
    if (f == 3'd6) begin
      b.imm32 = 64'(ins[24:20]);
      b.imm64 = 64'(ins[25:20]);
    end else begin
      b.imm64 = v;
      b.imm32 = v & 64'hFFFF_FFFF;
    end
    b.fmt = f;
    b.ill = il;
    b.tag = tg;
    return b;
  endfunction

  // One clock cycle: drive inputs, compare outputs against the model before
  // the edge, then advance the model with the handshakes that occurred.
  task automatic applyStimulus(input logic v, input logic [31:0] ins,
                               input logic [TAG_W-1:0] tg, input logic ordy,
                               input logic fl);
    logic do_push, do_pop;
    beat_t b;
    in_valid   = v;
    in_instr   = ins;
    in_tag     = tg;
    out_ready  = ordy;
    flush      = fl;
    in_imm_sel = 3'($urandom_range(0, 7));
    #3;
    checkOutput("in_ready", 64'(in_ready), 64'(model_q.size() != DEPTH));
    checkOutput("out_valid", 64'(out_valid), 64'(model_q.size() != 0));
    checkOutput("w_out_valid", 64'(w_out_valid), 64'(model_q.size() != 0));
    if (model_q.size() != 0) begin
      checkOutput("out_imm", 64'(out_imm), model_q[0].imm32);
      checkOutput("w_out_imm", w_out_imm, model_q[0].imm64);
      checkOutput("out_fmt", 64'(out_fmt), 64'(model_q[0].fmt));
      checkOutput("w_out_fmt", 64'(w_out_fmt), 64'(model_q[0].fmt));
      checkOutput("out_illegal", 64'(out_illegal), 64'(model_q[0].ill));
      checkOutput("out_tag", 64'(out_tag), 64'(model_q[0].tag));
      checkOutput("w_out_tag", 64'(w_out_tag), 64'(model_q[0].tag));
    end else begin
      checkOutput("idle_outputs",
                  {27'(out_imm), out_fmt, out_illegal, out_tag}, 64'd0);
    end
    checkOutput("illegal_cnt", 64'(illegal_cnt), 64'(ill_model));
    checkOutput("w_illegal_cnt", 64'(w_illegal_cnt), 64'(ill_model));
    do_pop  = (model_q.size() != 0) && ordy && !fl;
    do_push = v && (model_q.size() != DEPTH) && !fl;
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
        b = refDecode(ins, tg);
        model_q.push_back(b);
        if (b.ill && ill_model < 65535) ill_model++;
      end
    end
    #1;
  endtask

  logic [6:0] ops [10] = '{7'h33, 7'h03, 7'h67, 7'h73, 7'h13,
                           7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

  function automatic logic [31:0] randInstr();
    logic [31:0] r;
    int idx;
    r   = $urandom();
    idx = $urandom_range(0, 10);
    if (idx == 10) return r;
    return {r[31:7], ops[idx]};
  endfunction

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset state, checked while reset is still asserted.
    #2;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_illegal_cnt", 64'(illegal_cnt), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);

    // Directed decode vectors, each visible right after its accept edge.
    applyStimulus(1'b1, 32'hFFF00093, 5'd1, 1'b0, 1'b0);
    checkOutput("i_valid", 64'(out_valid), 64'd1);
    checkOutput("i_imm", 64'(out_imm), 64'hFFFF_FFFF);
    checkOutput("i_fmt", 64'(out_fmt), 64'd1);
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'hFE112E23, 5'd2, 1'b0, 1'b0);
    checkOutput("s_imm", 64'(out_imm), 64'hFFFF_FFFC);
    checkOutput("s_fmt", 64'(out_fmt), 64'd2);
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h00000463, 5'd3, 1'b0, 1'b0);
    checkOutput("b_imm", 64'(out_imm), 64'h8);
    checkOutput("b_fmt", 64'(out_fmt), 64'd3);
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h123450B7, 5'd4, 1'b0, 1'b0);
    checkOutput("u_imm", 64'(out_imm), 64'h1234_5000);
    checkOutput("u_fmt", 64'(out_fmt), 64'd4);
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h41F0D093, 5'd5, 1'b0, 1'b0);
    checkOutput("srai_imm", 64'(out_imm), 64'h1F);
    checkOutput("srai_fmt", 64'(out_fmt), 64'd6);
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h43F0D093, 5'd6, 1'b0, 1'b0);
    checkOutput("srai64_imm", w_out_imm, 64'h3F);
    checkOutput("srai32_imm", 64'(out_imm), 64'h1F);
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0000007F, 5'd7, 1'b0, 1'b0);
    checkOutput("ill_flag", 64'(out_illegal), 64'd1);
    checkOutput("ill_imm", 64'(out_imm), 64'd0);
    checkOutput("ill_cnt", 64'(illegal_cnt), 64'd1);
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);

    // Backpressure: fill, try an extra beat, then drain in order.
    applyStimulus(1'b1, 32'h00100093, 5'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00200093, 5'd2, 1'b0, 1'b0);
    checkOutput("bp_full_in_ready", 64'(in_ready), 64'd0);
    applyStimulus(1'b1, 32'h00300093, 5'd3, 1'b0, 1'b0);
    checkOutput("bp_hold_tag", 64'(out_tag), 64'd1);
    applyStimulus(1'b1, 32'h00400093, 5'd4, 1'b1, 1'b0);
    checkOutput("bp_second_tag", 64'(out_tag), 64'd2);
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
    checkOutput("bp_drained", 64'(out_valid), 64'd0);

    // Flush a full buffer together with an incoming beat.
    applyStimulus(1'b1, 32'h00500093, 5'd10, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00600093, 5'd11, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00700093, 5'd12, 1'b0, 1'b1);
    checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
    checkOutput("flush_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);

    // Reset mid-stream between edges.
    applyStimulus(1'b1, 32'h0000007F, 5'd13, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00800093, 5'd14, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_illegal_cnt", 64'(illegal_cnt), 64'd0);
    model_q.delete();
    ill_model = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), randInstr(),
                    TAG_W'($urandom()), ($urandom_range(0, 9) < 7),
                    ($urandom_range(0, 31) == 0));
    end

    // Saturation of the illegal counter, then flush must not clear it.
    for (int i = 0; i < 65540; i++)
      applyStimulus(1'b1, 32'h0000007F, TAG_W'(i), 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
    checkOutput("sat_cnt", 64'(illegal_cnt), 64'hFFFF);
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
    checkOutput("sat_after_flush", 64'(illegal_cnt), 64'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
